// File: rtl/pipelined_ctrl_unit.sv
// RV32 ID decode and registered EX/MEM/WB control bundle.
// Load-use stall, branch flush and a multi-cycle RV32M freeze in EX.
module pipelined_ctrl_unit #(
  parameter int M_EXT      = 1,
  parameter int MULDIV_LAT = 4,
  parameter int ALU_CTRL_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [6:0]            opcode,
  input  logic [2:0]            fun3,
  input  logic [6:0]            fun7,
  input  logic [4:0]            id_rs1,
  input  logic [4:0]            id_rs2,
  input  logic [4:0]            id_rd,
  input  logic                  ex_flush,
  output logic                  id_stall,
  output logic                  ex_valid,
  output logic [ALU_CTRL_W-1:0] ex_alu_control,
  output logic [2:0]            ex_imm_sel,
  output logic                  ex_operand_a,
  output logic                  ex_operand_b,
  output logic                  ex_branch,
  output logic                  ex_jal,
  output logic                  ex_jalr,
  output logic                  ex_illegal,
  output logic                  muldiv_busy,
  output logic                  mem_valid,
  output logic                  mem_load,
  output logic                  mem_store,
  output logic                  mem_en,
  output logic [2:0]            mem_fun3,
  output logic                  wb_valid,
  output logic                  wb_reg_write,
  output logic [1:0]            wb_mem_to_reg,
  output logic [4:0]            wb_rd
);

  localparam int CNT_W =
    (MULDIV_LAT > 1) ? $clog2(MULDIV_LAT) : 1;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_OPI   = 7'b0010011;
  localparam logic [6:0] OP_OP    = 7'b0110011;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  localparam logic [3:0] A_ADD  = 4'd0;
  localparam logic [3:0] A_SUB  = 4'd1;
  localparam logic [3:0] A_SLL  = 4'd2;
  localparam logic [3:0] A_SLT  = 4'd3;
  localparam logic [3:0] A_SLTU = 4'd4;
  localparam logic [3:0] A_XOR  = 4'd5;
  localparam logic [3:0] A_SRL  = 4'd6;
  localparam logic [3:0] A_SRA  = 4'd7;
  localparam logic [3:0] A_OR   = 4'd8;
  localparam logic [3:0] A_AND  = 4'd9;

  typedef struct packed {
    logic                  valid;
    logic [ALU_CTRL_W-1:0] alu;
    logic [2:0]            imm_sel;
    logic                  op_a;
    logic                  op_b;
    logic                  branch;
    logic                  jal;
    logic                  jalr;
    logic                  illegal;
    logic                  muldiv;
    logic                  load;
    logic                  store;
    logic [2:0]            fun3;
    logic                  reg_write;
    logic [1:0]            mem_to_reg;
    logic [4:0]            rd;
  } ctrl_t;

  function automatic logic [3:0] f_base_alu(
    input logic [2:0] f3,
    input logic       alt
  );
    logic [3:0] v;
    case (f3)
      3'd0:    v = alt ? A_SUB : A_ADD;
      3'd1:    v = A_SLL;
      3'd2:    v = A_SLT;
      3'd3:    v = A_SLTU;
      3'd4:    v = A_XOR;
      3'd5:    v = alt ? A_SRA : A_SRL;
      3'd6:    v = A_OR;
      default: v = A_AND;
    endcase
    return v;
  endfunction

  logic w_lui, w_auipc, w_jal, w_jalr, w_br;
  logic w_ld, w_st, w_opi, w_op, w_mop, w_m_ok;
  logic w_wr, w_use_rs1, w_use_rs2;
  logic w_hazard, w_busy;
  ctrl_t w_dec, w_ex_nxt, w_mem_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;

  ctrl_t r_ex, r_mem, r_wb;
  logic [CNT_W-1:0] r_cnt;

  assign w_lui   = opcode == OP_LUI;
  assign w_auipc = opcode == OP_AUIPC;
  assign w_jal   = opcode == OP_JAL;
  assign w_jalr  = opcode == OP_JALR;
  assign w_br    = opcode == OP_BR;
  assign w_ld    = opcode == OP_LD;
  assign w_st    = opcode == OP_ST;
  assign w_opi   = opcode == OP_OPI;
  assign w_op    = opcode == OP_OP;
  assign w_mop   = w_op & (fun7 == 7'b0000001);
  assign w_m_ok  = M_EXT != 0;

  always_comb begin
    w_dec = '0;
    w_wr  = 1'b0;
    unique case (1'b1)
      w_lui: begin
        w_dec.imm_sel = IMM_U;
        w_dec.op_b    = 1'b1;
        w_wr          = 1'b1;
      end
      w_auipc: begin
        w_dec.imm_sel = IMM_U;
        w_dec.op_a    = 1'b1;
        w_dec.op_b    = 1'b1;
        w_wr          = 1'b1;
      end
      w_jal: begin
        w_dec.imm_sel    = IMM_J;
        w_dec.op_a       = 1'b1;
        w_dec.op_b       = 1'b1;
        w_dec.jal        = 1'b1;
        w_dec.mem_to_reg = WB_PC4;
        w_wr             = 1'b1;
      end
      w_jalr: begin
        w_dec.imm_sel    = IMM_I;
        w_dec.op_b       = 1'b1;
        w_dec.jalr       = 1'b1;
        w_dec.mem_to_reg = WB_PC4;
        w_wr             = 1'b1;
      end
      w_br: begin
        w_dec.imm_sel = IMM_B;
        w_dec.branch  = 1'b1;
        w_dec.alu     = ALU_CTRL_W'(A_SUB);
      end
      w_ld: begin
        w_dec.imm_sel    = IMM_I;
        w_dec.op_b       = 1'b1;
        w_dec.load       = 1'b1;
        w_dec.fun3       = fun3;
        w_dec.mem_to_reg = WB_MEM;
        w_wr             = 1'b1;
      end
      w_st: begin
        w_dec.imm_sel = IMM_S;
        w_dec.op_b    = 1'b1;
        w_dec.store   = 1'b1;
        w_dec.fun3    = fun3;
      end
      w_opi: begin
        w_dec.imm_sel = IMM_I;
        w_dec.op_b    = 1'b1;
        w_dec.alu     = ALU_CTRL_W'(f_base_alu(
          fun3, (fun3 == 3'd5) & fun7[5]));
        w_wr          = 1'b1;
      end
      w_op & ~w_mop: begin
        w_dec.alu = ALU_CTRL_W'(f_base_alu(fun3, fun7[5]));
        w_wr      = 1'b1;
      end
      w_mop & w_m_ok: begin
        w_dec.alu    = ALU_CTRL_W'({2'b10, fun3});
        w_dec.muldiv = 1'b1;
        w_wr         = 1'b1;
      end
      default: w_dec.illegal = 1'b1;
    endcase
    w_dec.valid     = 1'b1;
    w_dec.rd        = id_rd;
    w_dec.reg_write = w_wr & (id_rd != 5'd0);
    if (!id_valid) w_dec = '0;
  end

  assign w_use_rs1 = id_valid & ~(w_lui | w_auipc | w_jal);
  assign w_use_rs2 = id_valid & (w_op | w_st | w_br);

  assign w_hazard = r_ex.valid & r_ex.load
    & (r_ex.rd != 5'd0)
    & ((w_use_rs1 & (id_rs1 == r_ex.rd))
     | (w_use_rs2 & (id_rs2 == r_ex.rd)));

  assign w_busy   = r_cnt != '0;
  assign id_stall = w_busy | (w_hazard & ~ex_flush);

  // busy hold > flush bubble > load-use bubble > normal
  always_comb begin
    w_ex_nxt  = w_dec;
    w_mem_nxt = r_ex;
    w_cnt_nxt = '0;
    if (w_busy) begin
      w_ex_nxt  = r_ex;
      w_mem_nxt = '0;
      w_cnt_nxt = r_cnt - 1'b1;
    end else if (ex_flush | w_hazard) begin
      w_ex_nxt = '0;
    end else if (w_dec.muldiv) begin
      w_cnt_nxt = CNT_W'(MULDIV_LAT - 1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex  <= '0;
      r_mem <= '0;
      r_wb  <= '0;
      r_cnt <= '0;
    end else begin
      r_ex  <= w_ex_nxt;
      r_mem <= w_mem_nxt;
      r_wb  <= r_mem;
      r_cnt <= w_cnt_nxt;
    end
  end

  assign ex_valid       = r_ex.valid;
  assign ex_alu_control = r_ex.alu;
  assign ex_imm_sel     = r_ex.imm_sel;
  assign ex_operand_a   = r_ex.op_a;
  assign ex_operand_b   = r_ex.op_b;
  assign ex_branch      = r_ex.branch;
  assign ex_jal         = r_ex.jal;
  assign ex_jalr        = r_ex.jalr;
  assign ex_illegal     = r_ex.illegal;
  assign muldiv_busy    = w_busy;
  assign mem_valid      = r_mem.valid;
  assign mem_load       = r_mem.load;
  assign mem_store      = r_mem.store;
  assign mem_en         = r_mem.load | r_mem.store;
  assign mem_fun3       = r_mem.fun3;
  assign wb_valid       = r_wb.valid;
  assign wb_reg_write   = r_wb.reg_write;
  assign wb_mem_to_reg  = r_wb.mem_to_reg;
  assign wb_rd          = r_wb.rd;

endmodule

// File: tb/tb_pipelined_ctrl_unit.sv
// Self-checking bench for pipelined_ctrl_unit.
// Random and directed streams against an instruction-level model.
`timescale 1ns/1ps
module tb_pipelined_ctrl_unit;

  localparam int LAT = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [6:0] opcode;
  logic [2:0] fun3;
  logic [6:0] fun7;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       ex_flush;

  always #5 clk = ~clk;

  typedef struct packed {
    logic       stall;
    logic       ex_v;
    logic [4:0] alu;
    logic [2:0] imm;
    logic       a, b, br, jal, jalr, ill, busy;
    logic       mem_v, ld, st, en;
    logic [2:0] mf3;
    logic       wb_v, rw;
    logic [1:0] m2r;
    logic [4:0] rd;
  } out_t;

  typedef struct packed {
    logic       v;
    logic [4:0] alu;
    logic [2:0] imm;
    logic       a, b, br, jal, jalr, ill, md, ld, st;
    logic [2:0] f3;
    logic       rw;
    logic [1:0] m2r;
    logic [4:0] rd;
  } rec_t;

  typedef struct packed {
    logic       v;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] rs1, rs2, rd;
  } ins_t;

  logic a_stall, a_exv, a_opa, a_opb, a_br, a_jal;
  logic a_jalr, a_ill, a_busy, a_memv, a_ld, a_st;
  logic a_en, a_wbv, a_rw;
  logic [4:0] a_alu, a_rd;
  logic [2:0] a_imm, a_mf3;
  logic [1:0] a_m2r;
  logic b_stall, b_exv, b_opa, b_opb, b_br, b_jal;
  logic b_jalr, b_ill, b_busy, b_memv, b_ld, b_st;
  logic b_en, b_wbv, b_rw;
  logic [4:0] b_alu, b_rd;
  logic [2:0] b_imm, b_mf3;
  logic [1:0] b_m2r;
  out_t oa, ob;

  pipelined_ctrl_unit #(
    .M_EXT(1), .MULDIV_LAT(LAT), .ALU_CTRL_W(5)
  ) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .opcode(opcode), .fun3(fun3), .fun7(fun7),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .ex_flush(ex_flush), .id_stall(a_stall),
    .ex_valid(a_exv), .ex_alu_control(a_alu),
    .ex_imm_sel(a_imm), .ex_operand_a(a_opa),
    .ex_operand_b(a_opb), .ex_branch(a_br),
    .ex_jal(a_jal), .ex_jalr(a_jalr),
    .ex_illegal(a_ill), .muldiv_busy(a_busy),
    .mem_valid(a_memv), .mem_load(a_ld),
    .mem_store(a_st), .mem_en(a_en),
    .mem_fun3(a_mf3), .wb_valid(a_wbv),
    .wb_reg_write(a_rw), .wb_mem_to_reg(a_m2r),
    .wb_rd(a_rd)
  );

  pipelined_ctrl_unit #(
    .M_EXT(0), .MULDIV_LAT(LAT), .ALU_CTRL_W(5)
  ) dut0 (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .opcode(opcode), .fun3(fun3), .fun7(fun7),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .ex_flush(ex_flush), .id_stall(b_stall),
    .ex_valid(b_exv), .ex_alu_control(b_alu),
    .ex_imm_sel(b_imm), .ex_operand_a(b_opa),
    .ex_operand_b(b_opb), .ex_branch(b_br),
    .ex_jal(b_jal), .ex_jalr(b_jalr),
    .ex_illegal(b_ill), .muldiv_busy(b_busy),
    .mem_valid(b_memv), .mem_load(b_ld),
    .mem_store(b_st), .mem_en(b_en),
    .mem_fun3(b_mf3), .wb_valid(b_wbv),
    .wb_reg_write(b_rw), .wb_mem_to_reg(b_m2r),
    .wb_rd(b_rd)
  );

  assign oa = {a_stall, a_exv, a_alu, a_imm, a_opa, a_opb,
    a_br, a_jal, a_jalr, a_ill, a_busy, a_memv, a_ld,
    a_st, a_en, a_mf3, a_wbv, a_rw, a_m2r, a_rd};
  assign ob = {b_stall, b_exv, b_alu, b_imm, b_opa, b_opb,
    b_br, b_jal, b_jalr, b_ill, b_busy, b_memv, b_ld,
    b_st, b_en, b_mf3, b_wbv, b_rw, b_m2r, b_rd};

  rec_t m_ex, m_mem, m_wb;
  int   m_cyc;
  bit   m_mext;
  ins_t prog[$];
  int   vecs, errs;

  function automatic ins_t mk(
    input logic [6:0] op, input logic [2:0] f3,
    input logic [6:0] f7, input logic [4:0] rs1,
    input logic [4:0] rs2, input logic [4:0] rd
  );
    ins_t i;
    i.v = 1'b1; i.op = op; i.f3 = f3; i.f7 = f7;
    i.rs1 = rs1; i.rs2 = rs2; i.rd = rd;
    return i;
  endfunction

  // instruction-level decode straight from the ISA table
  function automatic rec_t m_decode(
    input ins_t i, input bit mext
  );
    int   base[8] = '{0, 2, 3, 4, 5, 6, 8, 9};
    rec_t r;
    int   alt;
    r = '0;
    if (!i.v) return r;
    r.v  = 1'b1;
    r.rd = i.rd;
    case (i.op)
      7'h37: begin r.imm = 3'd3; r.b = 1; r.rw = 1; end
      7'h17: begin
        r.imm = 3'd3; r.a = 1; r.b = 1; r.rw = 1;
      end
      7'h6F: begin
        r.imm = 3'd4; r.a = 1; r.b = 1; r.jal = 1;
        r.rw = 1; r.m2r = 2'd2;
      end
      7'h67: begin
        r.b = 1; r.jalr = 1; r.rw = 1; r.m2r = 2'd2;
      end
      7'h63: begin r.imm = 3'd2; r.br = 1; r.alu = 5'd1; end
      7'h03: begin
        r.b = 1; r.ld = 1; r.f3 = i.f3;
        r.rw = 1; r.m2r = 2'd1;
      end
      7'h23: begin
        r.imm = 3'd1; r.b = 1; r.st = 1; r.f3 = i.f3;
      end
      7'h13: begin
        alt = (i.f3 == 3'd5 && i.f7[5]) ? 1 : 0;
        r.b = 1; r.rw = 1;
        r.alu = 5'(base[i.f3] + alt);
      end
      7'h33: begin
        if (i.f7 == 7'd1) begin
          if (mext) begin
            r.alu = 5'(16 + int'(i.f3));
            r.md = 1; r.rw = 1;
          end else r.ill = 1;
        end else begin
          alt = (i.f7[5] && (i.f3 == 3'd0 || i.f3 == 3'd5))
            ? 1 : 0;
          r.alu = 5'(base[i.f3] + alt);
          r.rw = 1;
        end
      end
      default: r.ill = 1;
    endcase
    r.rw = r.rw && (i.rd != 5'd0);
    return r;
  endfunction

  function automatic bit m_busy();
    return m_ex.v && m_ex.md && (m_cyc < LAT);
  endfunction

  task automatic m_reset();
    m_ex = '0; m_mem = '0; m_wb = '0; m_cyc = 0;
    prog.delete();
  endtask

  // one clock: present ID, predict, sample at negedge, advance
  task automatic tick(
    input bit flush, input bit on_b,
    output out_t exp, output out_t act
  );
    ins_t i;
    rec_t d;
    bit   u1, u2, busy, haz, stall;
    i = '0;
    if (prog.size() > 0) i = prog[0];
    id_valid = i.v; opcode = i.op; fun3 = i.f3;
    fun7 = i.f7; id_rs1 = i.rs1; id_rs2 = i.rs2;
    id_rd = i.rd; ex_flush = flush;
    @(negedge clk);
    d  = m_decode(i, m_mext);
    u1 = i.v && !(i.op inside {7'h37, 7'h17, 7'h6F});
    u2 = i.v && (i.op inside {7'h33, 7'h23, 7'h63});
    busy = m_busy();
    haz = m_ex.v && m_ex.ld && (m_ex.rd != 5'd0) &&
      ((u1 && i.rs1 == m_ex.rd) || (u2 && i.rs2 == m_ex.rd));
    stall = busy || (haz && !flush);
    exp = {stall, m_ex.v, m_ex.alu, m_ex.imm, m_ex.a,
      m_ex.b, m_ex.br, m_ex.jal, m_ex.jalr, m_ex.ill, busy,
      m_mem.v, m_mem.ld, m_mem.st, m_mem.ld | m_mem.st,
      m_mem.f3, m_wb.v, m_wb.rw, m_wb.m2r, m_wb.rd};
    act = on_b ? ob : oa;
    m_wb = m_mem;
    if (busy) begin
      m_mem = '0;
      m_cyc++;
    end else begin
      m_mem = m_ex;
      m_ex  = (flush || haz) ? '0 : d;
      m_cyc = 1;
    end
    if (!stall && prog.size() > 0) void'(prog.pop_front());
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    id_valid = 1'b1; opcode = 7'h03; id_rd = 5'd5;
    @(negedge clk);
    vecs++;
    if (oa !== '0) begin
      errs++; $display("FAIL reset_a got %h want 0", oa);
    end
    vecs++;
    if (ob !== '0) begin
      errs++; $display("FAIL reset_b got %h want 0", ob);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    m_reset();
  endtask

  task automatic test_alu();
    out_t e, a;
    prog.push_back(mk(7'h33, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3));
    for (int c = 0; c < 5; c++) begin
      tick(1'b0, 1'b0, e, a);
      vecs++;
      if (a !== e) begin
        errs++; $display("FAIL alu_c%0d got %h want %h", c, a, e);
      end
      if (c == 1) begin
        vecs++;
        if (a.ex_v !== 1'b1 || a.alu !== 5'd0) begin
          errs++;
          $display("FAIL add_ex got v=%b alu=%0d want 1/0",
            a.ex_v, a.alu);
        end
      end
      if (c == 3) begin
        vecs++;
        if (a.rw !== 1'b1 || a.rd !== 5'd3) begin
          errs++;
          $display("FAIL add_wb got rw=%b rd=%0d want 1/3",
            a.rw, a.rd);
        end
      end
    end
  endtask

  task automatic test_load_use();
    out_t e, a;
    int st;
    st = 0;
    prog.push_back(mk(7'h03, 3'd2, 7'd0, 5'd1, 5'd0, 5'd5));
    prog.push_back(mk(7'h33, 3'd0, 7'd0, 5'd5, 5'd2, 5'd6));
    for (int c = 0; c < 6; c++) begin
      tick(1'b0, 1'b0, e, a);
      vecs++;
      if (a !== e) begin
        errs++; $display("FAIL lu_c%0d got %h want %h", c, a, e);
      end
      if (a.stall === 1'b1) st++;
      if (c == 2) begin
        vecs++;
        if (a.ex_v !== 1'b0) begin
          errs++; $display("FAIL lu_bubble got %b want 0", a.ex_v);
        end
      end
      if (c == 3) begin
        vecs++;
        if (a.ex_v !== 1'b1 || a.alu !== 5'd0) begin
          errs++;
          $display("FAIL lu_add got v=%b alu=%0d want 1/0",
            a.ex_v, a.alu);
        end
      end
    end
    vecs++;
    if (st != 1) begin
      errs++; $display("FAIL lu_stalls got %0d want 1", st);
    end
  endtask

  task automatic test_muldiv();
    out_t e, a;
    int nb, ns, nm;
    bit seen;
    nb = 0; ns = 0; nm = 0; seen = 0;
    prog.push_back(mk(7'h33, 3'd0, 7'd1, 5'd1, 5'd2, 5'd7));
    prog.push_back(mk(7'h33, 3'd0, 7'd0, 5'd1, 5'd2, 5'd8));
    for (int c = 0; c < 9; c++) begin
      tick(1'b0, 1'b0, e, a);
      vecs++;
      if (a !== e) begin
        errs++; $display("FAIL md_c%0d got %h want %h", c, a, e);
      end
      if (a.busy === 1'b1) nb++;
      if (a.stall === 1'b1) ns++;
      if (c >= 2 && c <= 4 && a.mem_v === 1'b0) nm++;
      if (a.rw === 1'b1 && a.rd === 5'd7) seen = 1;
    end
    vecs++;
    if (nb != LAT - 1 || ns != LAT - 1 || nm != LAT - 1) begin
      errs++;
      $display("FAIL md_counts got busy=%0d stall=%0d mem=%0d want 3",
        nb, ns, nm);
    end
    vecs++;
    if (!seen) begin
      errs++; $display("FAIL md_wb got none want rd=7 write");
    end
  endtask

  task automatic test_flush_hazard();
    out_t e, a;
    prog.push_back(mk(7'h03, 3'd2, 7'd0, 5'd1, 5'd0, 5'd5));
    prog.push_back(mk(7'h33, 3'd0, 7'd0, 5'd5, 5'd2, 5'd6));
    for (int c = 0; c < 5; c++) begin
      tick(c == 1, 1'b0, e, a);
      vecs++;
      if (a !== e) begin
        errs++; $display("FAIL fl_c%0d got %h want %h", c, a, e);
      end
      if (c == 1) begin
        vecs++;
        if (a.stall !== 1'b0) begin
          errs++; $display("FAIL fl_stall got %b want 0", a.stall);
        end
      end
      if (c == 2) begin
        vecs++;
        if (a.ex_v !== 1'b0) begin
          errs++; $display("FAIL fl_ex got %b want 0", a.ex_v);
        end
      end
    end
  endtask

  task automatic test_illegal();
    out_t e, a;
    for (int k = 0; k < 2; k++) begin
      do_reset();
      m_mext = (k == 0);
      if (k == 0)
        prog.push_back(mk(7'h7F, 3'd0, 7'd0, 5'd1, 5'd2, 5'd4));
      else
        prog.push_back(mk(7'h33, 3'd0, 7'd1, 5'd1, 5'd2, 5'd7));
      for (int c = 0; c < 5; c++) begin
        tick(1'b0, k == 1, e, a);
        vecs++;
        if (a !== e) begin
          errs++;
          $display("FAIL ill%0d_c%0d got %h want %h", k, c, a, e);
        end
        if (c == 1) begin
          vecs++;
          if (a.ill !== 1'b1 || a.ex_v !== 1'b1 || a.busy !== 1'b0)
          begin
            errs++;
            $display("FAIL ill%0d_ex got ill=%b v=%b busy=%b want 1/1/0",
              k, a.ill, a.ex_v, a.busy);
          end
        end
        if (c == 2) begin
          vecs++;
          if (a.en !== 1'b0 || a.mem_v !== 1'b1) begin
            errs++;
            $display("FAIL ill%0d_mem got en=%b v=%b want 0/1",
              k, a.en, a.mem_v);
          end
        end
        if (c == 3) begin
          vecs++;
          if (a.rw !== 1'b0 || a.wb_v !== 1'b1) begin
            errs++;
            $display("FAIL ill%0d_wb got rw=%b v=%b want 0/1",
              k, a.rw, a.wb_v);
          end
        end
      end
    end
    m_mext = 1'b1;
  endtask

  task automatic test_reset_busy();
    out_t e, a;
    do_reset();
    prog.push_back(mk(7'h33, 3'd0, 7'd1, 5'd1, 5'd2, 5'd7));
    prog.push_back(mk(7'h33, 3'd0, 7'd0, 5'd1, 5'd2, 5'd9));
    tick(1'b0, 1'b0, e, a);
    tick(1'b0, 1'b0, e, a);
    vecs++;
    if (a.busy !== 1'b1) begin
      errs++; $display("FAIL rb_pre got busy=%b want 1", a.busy);
    end
    #2;
    rst = 1'b1;
    #1;
    vecs++;
    if (oa !== '0) begin
      errs++; $display("FAIL rb_async got %h want 0", oa);
    end
    m_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    prog.push_back(mk(7'h33, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3));
    for (int c = 0; c < 5; c++) begin
      tick(1'b0, 1'b0, e, a);
      vecs++;
      if (a !== e) begin
        errs++; $display("FAIL rb_c%0d got %h want %h", c, a, e);
      end
      if (c == 1) begin
        vecs++;
        if (a.ex_v !== 1'b1 || a.busy !== 1'b0) begin
          errs++;
          $display("FAIL rb_resume got v=%b busy=%b want 1/0",
            a.ex_v, a.busy);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [6:0] ops[12] = '{7'h37, 7'h17, 7'h6F, 7'h67,
      7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h33, 7'h7F, 7'h0F};
    logic [6:0] f7s[3] = '{7'h00, 7'h20, 7'h01};
    out_t e, a;
    ins_t i;
    bit fl;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      if (prog.size() == 0) begin
        i.v   = $urandom_range(0, 9) != 0;
        i.op  = ops[$urandom_range(0, 11)];
        i.f3  = 3'($urandom_range(0, 7));
        i.f7  = f7s[$urandom_range(0, 2)];
        i.rs1 = 5'($urandom_range(0, 3));
        i.rs2 = 5'($urandom_range(0, 3));
        i.rd  = 5'($urandom_range(0, 3));
        prog.push_back(i);
      end
      fl = !m_busy() && ($urandom_range(0, 9) == 0);
      tick(fl, 1'b0, e, a);
      vecs++;
      if (a !== e) begin
        errs++; $display("FAIL rnd_c%0d got %h want %h", c, a, e);
      end
    end
  endtask

  initial begin
    vecs = 0; errs = 0; m_mext = 1'b1;
    rst = 1'b0; id_valid = 1'b0; opcode = '0; fun3 = '0;
    fun7 = '0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    ex_flush = 1'b0;
    m_reset();
    @(posedge clk); #1;
    test_reset();
    test_alu();
    test_load_use();
    test_muldiv();
    test_flush_hazard();
    test_illegal();
    test_reset_busy();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
      vecs, errs);
    $finish;
  end

endmodule
